regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- MIPS general-purpose register file: 32 x 32-bit, two combinational read ports and one synchronous write port.
- The write port consumes the 5-bit destination register number produced by the RegDst select (rt vs rd) in write-back.
- A per-register busy scoreboard is set when an instruction with a destination issues and cleared when its write-back lands, so decode can detect RAW hazards.
- Sits between the decode stage (reads, issue) and the write-back stage (write).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; number of registers NREG = 2**ADDR_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- raddr1  input  ADDR_W  read port 1 address (rs)
- raddr2  input  ADDR_W  read port 2 address (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data
- busy1  output  1  raddr1 has an outstanding write not yet landed
- busy2  output  1  raddr2 has an outstanding write not yet landed
- we  input  1  write-back enable
- waddr  input  ADDR_W  write-back destination (from RegDst select)
- wdata  input  DATA_W  write-back data
- iss_valid  input  1  an instruction with a register destination issues this cycle
- iss_dest  input  ADDR_W  destination of issuing instruction

Behaviour:
- Reset (resetn=0, asynchronous): all registers cleared to 0 and all busy bits cleared to 0. Outputs are combinational, so during reset rdata1/rdata2=0 and busy1/busy2=0. Release is synchronous to the next clk edge.
- Write: on a rising edge with we=1 and waddr!=0, reg[waddr]<=wdata. Writes to register 0 are discarded.
- Read: combinational, zero latency.
  - rdataN = 0 if raddrN==0.
  - Otherwise rdataN = wdata if we=1 and waddr==raddrN (same-cycle write-through bypass).
  - Otherwise rdataN = reg[raddrN].
  - Both ports may read the same address; both get identical values.
- Scoreboard, on a rising edge:
  - if iss_valid=1 and iss_dest!=0: busy[iss_dest]<=1
  - if we=1 and waddr!=0: busy[waddr]<=0
  - Same index set and cleared in the same cycle: set wins, because the new producer is outstanding.
  - Different indices: both updates apply.
  - busy[0] is constant 0.
- busyN = busy[raddrN] & ~(we & waddr==raddrN), and 0 when raddrN==0. A write landing this cycle is already visible via the bypass, so it is not reported busy.
- Pipeline contract: at most one outstanding write per register. Decode stalls any issue whose iss_dest is busy. The block does not count multiple producers.
- A write with a clear busy bit is legal (e.g. after reset, or untracked); it updates data and leaves busy at 0.
- Reset mid-operation: all pending busy bits and data are lost. The pipeline must be flushed by the same reset.
- No X propagation: every register and busy bit has a defined reset value.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO=5'd0, and named constants for $ra (31) and $sp (29) used elsewhere in the CPU.
- One natural sub-module: regfile_read_port, instantiated twice. It holds the zero-check, bypass mux and busy qualification for one port.
- Storage array and busy vector live in the top module.

Test Plan:
- Reset: hold resetn=0 mid-cycle after writing reg 5=32'h1234 -> rdata for raddr1=5 is 0 immediately (async); busy1=0; after release reg 5 still reads 0.
- Zero register: we=1, waddr=0, wdata=32'hFFFF_FFFF; iss_valid=1, iss_dest=0 -> raddr1=0 gives rdata1=0 and busy1=0 in every cycle.
- Write then read: cycle n write reg 8=32'hDEAD_BEEF; cycle n+1 raddr2=8 -> rdata2=32'hDEAD_BEEF.
- Bypass: same cycle we=1, waddr=9, wdata=32'h55, raddr1=raddr2=9 -> rdata1=rdata2=32'h55 combinationally, and busy1=busy2=0 even with busy[9]=1.
- Scoreboard: issue dest 12 at cycle n -> busy1=1 (raddr1=12) from n+1; write-back we=1, waddr=12 at cycle n+3 -> busy1=0 during n+3 and after.
- Simultaneous set/clear: busy[7]=1; same edge iss_valid=1, iss_dest=7, we=1, waddr=7 -> busy[7] stays 1. Repeat with iss_dest=4 -> busy[7]=0 and busy[4]=1.

Source files
------------

// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared register-file constants for the decode/write-back boundary.
// Holds widths, the hardwired zero register and ABI register numbers used elsewhere in the CPU.
package regfile_wb_scoreboard_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: zero register, write-back bypass and busy qualification.
// Purely combinational; no backpressure, decode uses busy to stall.
module regfile_read_port
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] reg_dat,
   input  logic              busy_bit,
   output logic [DATA_W-1:0] rdata,
   output logic              busy
);

   logic wb_hit;

   always_comb begin
      wb_hit = we && (waddr == raddr);
      rdata  = reg_dat;
      busy   = busy_bit;
      if (raddr == '0) begin
         rdata = '0;
         busy  = 1'b0;
      end else if (wb_hit) begin
         // the landing write is already forwarded, so the operand is not stale
         rdata = wdata;
         busy  = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// MIPS 32x32 register file with write-back bypass and per-register RAW busy scoreboard.
// Reads are zero-latency; writes and busy updates land on the next clk edge; no backpressure.
module regfile_wb_scoreboard
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy1,
   output logic              busy2,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_dest
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
         busy_d[waddr] = 1'b0;
      end
      // issue applied after the clear: a new producer on the same index stays outstanding
      if (iss_valid && (iss_dest != '0)) begin
         busy_d[iss_dest] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .raddr    (raddr1),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .reg_dat  (regs_q[raddr1]),
      .busy_bit (busy_q[raddr1]),
      .rdata    (rdata1),
      .busy     (busy1)
   );

   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .raddr    (raddr2),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .reg_dat  (regs_q[raddr2]),
      .busy_bit (busy_q[raddr2]),
      .rdata    (rdata2),
      .busy     (busy2)
   );

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed cases plus random traffic against an array model.
module tb_regfile_wb_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] raddr1, raddr2, waddr, iss_dest;
   logic [DW-1:0] rdata1, rdata2, wdata;
   logic          busy1, busy2, we, iss_valid;

   regfile_wb_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .busy1     (busy1),
      .busy2     (busy2),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .iss_valid (iss_valid),
      .iss_dest  (iss_dest)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] m_reg  [NR];
   logic          m_busy [NR];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (we && waddr == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
      if (we && waddr == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      iss_valid = 1'b0; iss_dest = '0;
   endtask

   // Check all outputs against the model at negedge, then commit the edge into the model.
   task automatic cyc();
      @(negedge clk);
      chk("rdata1", rdata1, exp_rd(raddr1));
      chk("rdata2", rdata2, exp_rd(raddr2));
      chk("busy1", {31'd0, busy1}, {31'd0, exp_busy(raddr1)});
      chk("busy2", {31'd0, busy2}, {31'd0, exp_busy(raddr2)});
      @(posedge clk);
      if (!resetn) begin
         model_clear();
      end else begin
         if (we && waddr != 0) begin
            m_reg[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
         end
         if (iss_valid && iss_dest != 0) m_busy[iss_dest] = 1'b1;
      end
      #1;
   endtask

   initial begin
      resetn = 1'b1;
      idle();
      raddr1 = 5'd3; raddr2 = 5'd17;
      model_clear();
      #1 resetn = 1'b0;
      #1;
      chk("reset_rdata1", rdata1, 32'd0);
      chk("reset_rdata2", rdata2, 32'd0);
      chk("reset_busy1", {31'd0, busy1}, 32'd0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // Zero register ignores writes and issues
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      iss_valid = 1'b1; iss_dest = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("zero_rdata1", rdata1, 32'd0);
         chk("zero_busy1", {31'd0, busy1}, 32'd0);
         cyc();
      end

      // Write then read next cycle
      idle(); we = 1'b1; waddr = 5'd8; wdata = 32'hDEAD_BEEF; raddr2 = 5'd3;
      cyc();
      idle(); raddr2 = 5'd8;
      #1 chk("wr_rd_reg8", rdata2, 32'hDEAD_BEEF);
      cyc();

      // Bypass with busy suppression
      idle(); iss_valid = 1'b1; iss_dest = 5'd9;
      cyc();
      idle(); raddr1 = 5'd9; raddr2 = 5'd9;
      #1 chk("busy9_set", {31'd0, busy1}, 32'd1);
      we = 1'b1; waddr = 5'd9; wdata = 32'h55;
      #1;
      chk("byp_rdata1", rdata1, 32'h55);
      chk("byp_rdata2", rdata2, 32'h55);
      chk("byp_busy1", {31'd0, busy1}, 32'd0);
      chk("byp_busy2", {31'd0, busy2}, 32'd0);
      cyc();

      // Scoreboard lifetime of register 12
      idle(); iss_valid = 1'b1; iss_dest = 5'd12; raddr1 = 5'd12;
      cyc();
      for (int i = 1; i <= 4; i++) begin
         idle(); raddr1 = 5'd12;
         if (i == 3) begin
            we = 1'b1; waddr = 5'd12; wdata = 32'hC0DE_0012;
         end
         #1 chk($sformatf("sb12_n%0d", i), {31'd0, busy1}, (i < 3) ? 32'd1 : 32'd0);
         cyc();
      end

      // Simultaneous set and clear
      idle(); iss_valid = 1'b1; iss_dest = 5'd7;
      cyc();
      idle(); iss_valid = 1'b1; iss_dest = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h77;
      cyc();
      idle(); raddr1 = 5'd7;
      #1 chk("setclr_same_b7", {31'd0, busy1}, 32'd1);
      iss_valid = 1'b1; iss_dest = 5'd4; we = 1'b1; waddr = 5'd7; wdata = 32'h78;
      cyc();
      idle(); raddr1 = 5'd7; raddr2 = 5'd4;
      #1;
      chk("setclr_diff_b7", {31'd0, busy1}, 32'd0);
      chk("setclr_diff_b4", {31'd0, busy2}, 32'd1);
      cyc();

      // Reset mid-cycle loses data and busy
      idle(); iss_valid = 1'b1; iss_dest = 5'd5; we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
      cyc();
      idle(); raddr1 = 5'd5;
      #1;
      chk("pre_rst_rdata1", rdata1, 32'h1234);
      chk("pre_rst_busy1", {31'd0, busy1}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("rst_async_rdata1", rdata1, 32'd0);
      chk("rst_async_busy1", {31'd0, busy1}, 32'd0);
      model_clear();
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rdata1", rdata1, 32'd0);

      // Random traffic, mostly on a few registers to force collisions
      for (int i = 0; i < 600; i++) begin
         logic narrow;
         narrow    = ($urandom_range(0, 3) != 0);
         raddr1    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         raddr2    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         we        = ($urandom_range(0, 1) == 1);
         waddr     = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wdata     = $urandom;
         iss_valid = ($urandom_range(0, 2) != 0);
         iss_dest  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
